// File: rtl/width_alloc_pkg.sv
// Shared types and constants for the width allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package width_alloc_pkg;

    localparam int ID_W  = 4;
    localparam int OCC_W = 7;
    localparam int REQ_W = 5;

    localparam logic [REQ_W-1:0] MIN_WIDTH   = 5'd4;
    localparam logic [REQ_W-1:0] MAX_WIDTH   = 5'd16;
    localparam logic [ID_W-1:0]  SENTINEL_ID = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } state_e;

    // A request is only placed when its width lies in MIN_WIDTH..MAX_WIDTH.
    function automatic logic width_legal(input logic [REQ_W-1:0] w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/width_allocator_fit_select.sv
// Priority fit check of three candidate occupancies against CAPACITY.
// Latency: combinational.
// Backpressure: none.
module fit_select
    import width_alloc_pkg::*;
#(
    parameter int CAPACITY = 64
) (
    input  logic [OCC_W-1:0] occ1_i,
    input  logic [OCC_W-1:0] occ2_i,
    input  logic [OCC_W-1:0] occ3_i,
    input  logic [REQ_W-1:0] width_i,
    output logic             hit_o,
    output logic [1:0]       sel_o,
    output logic [OCC_W-1:0] new_occ_o
);

    localparam logic [7:0] CAP = 8'(CAPACITY);

    // Sums are 8 bits wide so a 127 occupancy plus any width cannot wrap into a fit.
    logic [7:0] sum1, sum2, sum3;
    assign sum1 = {1'b0, occ1_i} + {3'b000, width_i};
    assign sum2 = {1'b0, occ2_i} + {3'b000, width_i};
    assign sum3 = {1'b0, occ3_i} + {3'b000, width_i};

    // First fitting candidate in priority order 1, 2, 3; sel 0 means no fit.
    always_comb begin
        hit_o     = 1'b0;
        sel_o     = 2'd0;
        new_occ_o = '0;
        if (sum1 <= CAP) begin
            hit_o     = 1'b1;
            sel_o     = 2'd1;
            new_occ_o = sum1[OCC_W-1:0];
        end else if (sum2 <= CAP) begin
            hit_o     = 1'b1;
            sel_o     = 2'd2;
            new_occ_o = sum2[OCC_W-1:0];
        end else if (sum3 <= CAP) begin
            hit_o     = 1'b1;
            sel_o     = 2'd3;
            new_occ_o = sum3[OCC_W-1:0];
        end
    end

endmodule

// File: rtl/width_allocator.sv
// Reads three candidate occupancies, grants the first that fits and accumulates the width into the RAM.
// Latency: response 3 cycles after accept (1 cycle for an illegal width).
// Backpressure: one request in flight; req_ready low until the response handshake, rsp held while rsp_ready low.
// Optional: WIDTH_ALLOC_STATS_EN adds saturating grant/reject handshake counters.
module width_allocator
    import width_alloc_pkg::*;
#(
    parameter int CAPACITY = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [REQ_W-1:0] req_width,
    input  logic [ID_W-1:0]  req_id1,
    input  logic [ID_W-1:0]  req_id2,
    input  logic [ID_W-1:0]  req_id3,
    output logic             ram_en,
    output logic             ram_we,
    output logic [ID_W-1:0]  ram_id1,
    output logic [ID_W-1:0]  ram_id2,
    output logic [ID_W-1:0]  ram_id3,
    output logic [ID_W-1:0]  ram_write_id,
    output logic [REQ_W-1:0] ram_write_width,
    input  logic [OCC_W-1:0] ram_width1,
    input  logic [OCC_W-1:0] ram_width2,
    input  logic [OCC_W-1:0] ram_width3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_ok,
    output logic [ID_W-1:0]  rsp_id,
    output logic [OCC_W-1:0] rsp_occ
`ifdef WIDTH_ALLOC_STATS_EN
    ,
    output logic [15:0]      grant_cnt,
    output logic [15:0]      reject_cnt
`endif
);

    state_e            state_q, state_d;
    logic [REQ_W-1:0]  width_q, width_d;
    logic [ID_W-1:0]   id1_q, id1_d, id2_q, id2_d, id3_q, id3_d;
    logic              rsp_ok_q, rsp_ok_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [OCC_W-1:0]  rsp_occ_q, rsp_occ_d;

    logic              fit_hit;
    logic [1:0]        fit_sel;
    logic [OCC_W-1:0]  fit_occ;
    logic [ID_W-1:0]   sel_id;

    fit_select #(.CAPACITY(CAPACITY)) u_fit (
        .occ1_i    (ram_width1),
        .occ2_i    (ram_width2),
        .occ3_i    (ram_width3),
        .width_i   (width_q),
        .hit_o     (fit_hit),
        .sel_o     (fit_sel),
        .new_occ_o (fit_occ)
    );

    // Map the winning candidate index back to its latched ID.
    always_comb begin
        sel_id = '0;
        case (fit_sel)
            2'd1:    sel_id = id1_q;
            2'd2:    sel_id = id2_q;
            2'd3:    sel_id = id3_q;
            default: sel_id = '0;
        endcase
    end

    // State and request/response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            id1_q     <= '0;
            id2_q     <= '0;
            id3_q     <= '0;
            rsp_ok_q  <= 1'b0;
            rsp_id_q  <= '0;
            rsp_occ_q <= '0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            id1_q     <= id1_d;
            id2_q     <= id2_d;
            id3_q     <= id3_d;
            rsp_ok_q  <= rsp_ok_d;
            rsp_id_q  <= rsp_id_d;
            rsp_occ_q <= rsp_occ_d;
        end
    end

    // Next-state logic and RAM port drive; RAM strobes are killed while rst is high.
    always_comb begin
        state_d         = state_q;
        width_d         = width_q;
        id1_d           = id1_q;
        id2_d           = id2_q;
        id3_d           = id3_q;
        rsp_ok_d        = rsp_ok_q;
        rsp_id_d        = rsp_id_q;
        rsp_occ_d       = rsp_occ_q;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_id1         = '0;
        ram_id2         = '0;
        ram_id3         = '0;
        ram_write_id    = '0;
        ram_write_width = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    width_d = req_width;
                    id1_d   = req_id1;
                    id2_d   = req_id2;
                    id3_d   = req_id3;
                    if (width_legal(req_width)) begin
                        state_d = READ;
                    end else begin
                        rsp_ok_d  = 1'b0;
                        rsp_id_d  = '0;
                        rsp_occ_d = '0;
                        state_d   = RESP;
                    end
                end
            end
            READ: begin
                ram_en  = !rst;
                ram_id1 = id1_q;
                ram_id2 = id2_q;
                ram_id3 = id3_q;
                state_d = EVAL;
            end
            EVAL: begin
                ram_id1 = id1_q;
                ram_id2 = id2_q;
                ram_id3 = id3_q;
                if (fit_hit) begin
                    ram_en          = !rst;
                    ram_we          = !rst;
                    ram_write_id    = sel_id;
                    ram_write_width = width_q;
                end
                rsp_ok_d  = fit_hit;
                rsp_id_d  = fit_hit ? sel_id : '0;
                rsp_occ_d = fit_hit ? fit_occ : '0;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_ok    = rsp_ok_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_occ   = rsp_occ_q;

`ifdef WIDTH_ALLOC_STATS_EN
    logic [15:0] grant_cnt_q, reject_cnt_q;

    // Saturating counts of completed response handshakes, split by outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q  <= '0;
            reject_cnt_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_ok_q && grant_cnt_q != 16'hFFFF)
                grant_cnt_q <= grant_cnt_q + 16'd1;
            if (!rsp_ok_q && reject_cnt_q != 16'hFFFF)
                reject_cnt_q <= reject_cnt_q + 16'd1;
        end
    end

    assign grant_cnt  = grant_cnt_q;
    assign reject_cnt = reject_cnt_q;
`endif

endmodule

// File: tb/tb_width_allocator.sv
// Directed bench for width_allocator with a behavioural occupancy RAM.
// Latency: n/a.
// Backpressure: exercises rsp_ready held low.
module tb_width_allocator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_width = '0;
    logic [3:0] req_id1 = '0, req_id2 = '0, req_id3 = '0;
    logic       ram_en, ram_we;
    logic [3:0] ram_id1, ram_id2, ram_id3, ram_write_id;
    logic [4:0] ram_write_width;
    logic [6:0] ram_width1 = '0, ram_width2 = '0, ram_width3 = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_ok;
    logic [3:0] rsp_id;
    logic [6:0] rsp_occ;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    logic [6:0] mem [16];

    always #5 clk = ~clk;

    width_allocator #(.CAPACITY(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_width       (req_width),
        .req_id1         (req_id1),
        .req_id2         (req_id2),
        .req_id3         (req_id3),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_id1         (ram_id1),
        .ram_id2         (ram_id2),
        .ram_id3         (ram_id3),
        .ram_write_id    (ram_write_id),
        .ram_write_width (ram_write_width),
        .ram_width1      (ram_width1),
        .ram_width2      (ram_width2),
        .ram_width3      (ram_width3),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_ok          (rsp_ok),
        .rsp_id          (rsp_id),
        .rsp_occ         (rsp_occ)
    );

    function automatic logic [6:0] rd(input logic [3:0] id);
        return (id == 4'd13) ? 7'd127 : mem[id];
    endfunction

    // Occupancy RAM: registered reads, accumulate on write.
    always @(posedge clk) begin
        if (ram_en && !ram_we) begin
            ram_width1 <= rd(ram_id1);
            ram_width2 <= rd(ram_id2);
            ram_width3 <= rd(ram_id3);
        end
        if (ram_en && ram_we)
            mem[ram_write_id] <= mem[ram_write_id] + {2'b00, ram_write_width};
    end

    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (ram_en) en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a request from a negedge; returns negedges from accept edge to rsp_valid.
    task automatic do_req(input logic [4:0] w, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, output int lat);
        int n;
        req_width = w; req_id1 = a; req_id2 = b; req_id3 = c;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = 99;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int we0;
        int en0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset: strobes forced low while rst is high, all outputs at reset values.
        repeat (3) @(negedge clk);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_ok", rsp_ok, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_occ", rsp_occ, 0);
        check("rst_ram_addr", {ram_id1, ram_id2, ram_id3, ram_write_id}, 0);
        check("rst_ram_wdat", ram_write_width, 0);

        // Basic grant to the first candidate.
        we0 = we_cnt;
        do_req(5'd8, 4'd2, 4'd5, 4'd7, lat);
        check("t1_latency", lat, 3);
        check("t1_ok", rsp_ok, 1);
        check("t1_id", rsp_id, 2);
        check("t1_occ", rsp_occ, 8);
        check("t1_mem2", mem[2], 8);
        check("t1_writes", we_cnt - we0, 1);
        check("t1_req_ready_busy", req_ready, 0);
        finish_rsp();
        check("t1_back_idle", req_ready, 1);
        check("t1_rsp_drop", rsp_valid, 0);

        // First candidate would overflow (60+8=68), second fits.
        mem[2] = 7'd60;
        do_req(5'd8, 4'd2, 4'd5, 4'd13, lat);
        check("t2_latency", lat, 3);
        check("t2_ok", rsp_ok, 1);
        check("t2_id", rsp_id, 5);
        check("t2_occ", rsp_occ, 8);
        check("t2_mem2", mem[2], 60);
        check("t2_mem5", mem[5], 8);
        finish_rsp();

        // Sentinel ID never fits: reject without writing.
        we0 = we_cnt;
        do_req(5'd4, 4'd13, 4'd13, 4'd13, lat);
        check("t3_latency", lat, 3);
        check("t3_ok", rsp_ok, 0);
        check("t3_id", rsp_id, 0);
        check("t3_occ", rsp_occ, 0);
        check("t3_writes", we_cnt - we0, 0);
        finish_rsp();

        // Illegal widths: fast reject, RAM untouched.
        en0 = en_cnt;
        do_req(5'd3, 4'd1, 4'd2, 4'd3, lat);
        check("t4_w3_latency", lat, 1);
        check("t4_w3_ok", rsp_ok, 0);
        finish_rsp();
        do_req(5'd17, 4'd1, 4'd2, 4'd3, lat);
        check("t4_w17_latency", lat, 1);
        check("t4_w17_ok", rsp_ok, 0);
        check("t4_w17_id", rsp_id, 0);
        finish_rsp();
        check("t4_ram_en_cnt", en_cnt - en0, 0);

        // Exact fit at capacity, then hold the response under backpressure.
        mem[9] = 7'd48;
        do_req(5'd16, 4'd9, 4'd1, 4'd1, lat);
        check("t5_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", rsp_valid, 1);
            check("t5_hold_ok", rsp_ok, 1);
            check("t5_hold_id", rsp_id, 9);
            check("t5_hold_occ", rsp_occ, 64);
            check("t5_hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        check("t5_mem9", mem[9], 64);
        finish_rsp();

        // Duplicate candidates: a single write to the shared ID.
        we0 = we_cnt;
        do_req(5'd10, 4'd4, 4'd4, 4'd4, lat);
        check("t6_id", rsp_id, 4);
        check("t6_occ", rsp_occ, 10);
        check("t6_writes", we_cnt - we0, 1);
        check("t6_mem4", mem[4], 10);
        finish_rsp();

        // Reset during EVAL suppresses the write and drops the request.
        we0 = we_cnt;
        req_width = 5'd5; req_id1 = 4'd3; req_id2 = 4'd3; req_id3 = 4'd3;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t7_read_en", ram_en, 1);
        check("t7_read_we", ram_we, 0);
        @(negedge clk);
        check("t7_eval_we", ram_we, 1);
        rst = 1'b1;
        #1;
        check("t7_rst_we", ram_we, 0);
        check("t7_rst_en", ram_en, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t7_rsp_valid", rsp_valid, 0);
        check("t7_req_ready", req_ready, 1);
        check("t7_mem3", mem[3], 0);
        repeat (3) @(negedge clk);
        check("t7_still_idle", rsp_valid, 0);
        check("t7_writes", we_cnt - we0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
